// File: rtl/btn_debounce_bank.sv
// Multi-channel pin conditioner: optional inversion, synchroniser, debounce FSM and press/release pulses.
// Define BTN_DEBOUNCE_REPEAT_EN to build the auto-repeat counters; release/repeat are reserved words, hence *_pulse.
module btn_debounce_bank #(
  parameter int                  CHANNELS      = 5,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  STABLE_CYCLES = 1_000_000,
  parameter logic [CHANNELS-1:0] INVERT_MASK   = '0,
  parameter int                  REPEAT_DELAY  = 50_000_000,
  parameter int                  REPEAT_PERIOD = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_press
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PEND_PRESS, HELD, PEND_RELEASE} state_t;

  if (CHANNELS < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_check
    $error("btn_debounce_bank: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_d  [CHANNELS];
  state_t                 state_q [CHANNELS];
  state_t                 state_d [CHANNELS];
  logic [CW-1:0]          cnt_q   [CHANNELS];
  logic [CW-1:0]          cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]    s;
  logic [CHANNELS-1:0]    level_q, level_d;
  logic [CHANNELS-1:0]    press_q, press_d;
  logic [CHANNELS-1:0]    release_q, release_d;
  logic                   any_press_q, any_press_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], in[i] ^ INVERT_MASK[i]};
      s[i]      = sync_q[i][SYNC_STAGES-1];
    end
  end

  // A pending state counts consecutive cycles of the new value; any bounce back aborts it.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    level_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        RELEASED: if (s[i]) begin
          if (STABLE_CYCLES == 1) begin
            state_d[i] = HELD;
            press_d[i] = 1'b1;
          end else begin
            state_d[i] = PEND_PRESS;
            cnt_d[i]   = CW'(1);
          end
        end
        PEND_PRESS: begin
          if (!s[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        HELD: if (!s[i]) begin
          if (STABLE_CYCLES == 1) begin
            state_d[i]   = RELEASED;
            release_d[i] = 1'b1;
          end else begin
            state_d[i] = PEND_RELEASE;
            cnt_d[i]   = CW'(1);
          end
        end
        PEND_RELEASE: begin
          if (s[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = RELEASED;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
      level_d[i] = (state_d[i] == HELD) || (state_d[i] == PEND_RELEASE);
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]  <= sync_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= any_press_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign any_press     = any_press_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]       rcnt_q [CHANNELS];
  logic [RW-1:0]       rcnt_d [CHANNELS];
  logic [CHANNELS-1:0] rfirst_q, rfirst_d;
  logic [CHANNELS-1:0] repeat_q, repeat_d;

  // Counting only while held across the edge keeps repeat off press and release edges.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rcnt_d[i]   = '0;
      rfirst_d[i] = 1'b0;
      if (level_q[i] && level_d[i]) begin
        rcnt_d[i]   = rcnt_q[i] + RW'(1);
        rfirst_d[i] = rfirst_q[i];
        if (rcnt_d[i] == (rfirst_q[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
          repeat_d[i] = 1'b1;
          rcnt_d[i]   = '0;
          rfirst_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) rcnt_q[i] <= '0;
      rfirst_q <= '0;
      repeat_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) rcnt_q[i] <= rcnt_d[i];
      rfirst_q <= rfirst_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: doc/btn_debounce_bank.md
# btn_debounce_bank

Parametrised multi-channel successor to the single-input button conditioner used on the Au top level. It synchronises, debounces and optionally inverts up to CHANNELS asynchronous inputs (io_button, io_dip, rst_n). For each channel it produces a clean level plus single-cycle press/release pulses. An optional per-channel auto-repeat pulse can be compiled in. It sits between board pins and user logic such as HediosEndpoint slots, reset generation or counters, and runs entirely on the system clock with no derived clocks.

## Interface
- CHANNELS, 5: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- STABLE_CYCLES, 1_000_000: consecutive cycles a new synced value must persist before acceptance (≥1; 10 ms at 100 MHz).
- INVERT_MASK, 0 (CHANNELS bits): bit i = 1 inverts in[i] before synchronisation (active-low pins).
- REPEAT_DELAY, 50_000_000: cycles from press pulse to first repeat pulse (≥1).
- REPEAT_PERIOD, 10_000_000: cycles between subsequent repeat pulses (≥1).
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  CHANNELS  raw asynchronous inputs.
- level  output  CHANNELS  debounced, polarity-corrected level.
- press  output  CHANNELS  one-cycle pulse on accepted 0→1.
- release  output  CHANNELS  one-cycle pulse on accepted 1→0.
- repeat  output  CHANNELS  one-cycle auto-repeat pulse while held.
- any_press  output  1  OR of press, registered in the same cycle as press.

## Operation
- Per channel: x = in[i] ^ INVERT_MASK[i] → SYNC_STAGES-flop chain → s.
- Per-channel state machine and counter cnt, width $clog2(STABLE_CYCLES+1):
  - RELEASED (level=0): s=1 → PEND_PRESS, cnt=1 (if STABLE_CYCLES=1, go directly to HELD).
  - PEND_PRESS: s=0 → RELEASED, cnt=0. s=1 with cnt=STABLE_CYCLES-1 → HELD, level←1, press pulse. Otherwise cnt++.
  - HELD (level=1): mirror of RELEASED; s=0 → PEND_RELEASE.
  - PEND_RELEASE: s=1 → HELD. After STABLE_CYCLES consecutive s=0 → RELEASED, level←0, release pulse.
- Any bounce back to the current level during a pending state aborts it and clears cnt. Exactly one press per accepted transition.
- Repeat counter rcnt, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - Cleared on the press pulse.
  - Counts in HELD and PEND_RELEASE.
  - repeat pulses when rcnt reaches REPEAT_DELAY, then every REPEAT_PERIOD.
  - Cleared and stopped on release.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- Reset, all outputs 0: synchroniser flops 0, all channels RELEASED, cnt=rcnt=0, level/press/release/repeat/any_press=0. Takes effect asynchronously mid-operation, aborting pending transitions.
- An input already active when reset releases produces a normal press after the full latency. No suppression.

## Timing
- All outputs are registered.
- Input change set up before edge 0: s changes after edge SYNC_STAGES. level and press/release change after edge SYNC_STAGES+STABLE_CYCLES.
- Pulses are high for exactly one cycle, coincident with the level change.
- Pulses shorter than STABLE_CYCLES cycles at s never change level.
- First repeat pulse comes REPEAT_DELAY cycles after press; later pulses follow every REPEAT_PERIOD cycles.
- repeat never coincides with press. If release and a repeat are due on the same edge, release wins and repeat is suppressed.

## Configuration
- BTN_DEBOUNCE_REPEAT_EN defined: rcnt logic and repeat output active as above.
- Not defined: no rcnt registers synthesised, repeat tied to 0. All other behaviour identical.

## Test plan
Parameters: CHANNELS=3, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, INVERT_MASK=3'b100.
- Reset with in=3'b000: level=3'b100 after 6 cycles (ch2 inverted, held active), with press[2] one cycle. Assert rst mid-run: all outputs 0 in the same cycle.
- ch0 clean 0→1 before edge 0: level[0] and press[0] after edge 6, press high 1 cycle, any_press=1 same cycle. Clean 1→0 gives release[0] 6 edges later.
- ch1 glitch high for 3 cycles: level[1], press[1], release[1] stay 0 throughout.
- ch0 toggling every 2 cycles for 12 cycles then steady 1: exactly one press[0], at 6 edges after the final transition.
- ch0 held (macro defined): repeat[0] at 10, 13, 16… cycles after press. Release stops repeats and pulses release[0]. Without macro: repeat stays 0.
- ch0 press and ch1 release accepted on the same edge: press[0] and release[1] both pulse that cycle. rst asserted during PEND_PRESS: no press after reset releases unless input persists the full 6 cycles.
